// File: rtl/if_stage.sv
// if_stage: fetch PC, 1-cycle synchronous imem reads, 2-entry return queue to decode.
// Latency: first valid 2 cycles after reset release; a redirect target is valid 3 cycles after the redirect.
// Backpressure: id_ready_i low holds the head; issue stops once queued + in-flight entries reach 2.
// Build option: define IF_PERF_CNT_EN to add the perf_fetch_cnt_o / perf_bubble_cnt_o counters.

// sync_fifo: generic synchronous FIFO with a single-cycle flush.
// Latency: a pushed word is visible at head_dat the cycle after the push.
// Backpressure: none internally; the caller must not push when full unless it also pops.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  output logic [W-1:0]     head_dat,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping; a flush empties the FIFO and overrides push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= ptr_inc(tail_q);
      if (pop)  head_q <= ptr_inc(head_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents are only meaningful while count says so, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[tail_q] <= push_dat;
  end

  assign head_dat = mem_q[head_q];
  assign count    = count_q;

endmodule

module if_stage #(
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_en_o,
  output logic [PC_W-1:0]   imem_addr_o,
  input  logic [INST_W-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  input  logic              id_ready_i,
  output logic              if_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [PC_W-1:0]   pc_plus_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt_o,
  output logic [31:0]       perf_bubble_cnt_o
`endif
);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } entry_t;

  logic [PC_W-1:0] fetch_pc_q;
  logic [PC_W-1:0] issue_pc_q;
  logic            inflight_q;
  logic            kill_q;

  logic            deq;
  logic            enq;
  logic            issue;
  logic [2:0]      occupancy;
  logic [1:0]      q_count;
  entry_t          enq_entry;
  entry_t          head;

  // Head of the queue is what decode sees; everything downstream of it is registered.
  assign if_valid_o = (q_count != 2'd0);

  // A redirect discards the head, so it never counts as accepted.
  assign deq = if_valid_o & id_ready_i & ~redirect_i;

  // Slots already committed: queued entries plus the return still on its way, less the one leaving.
  assign occupancy = {1'b0, q_count} + {2'b00, inflight_q} - {2'b00, deq};

  // rst_n gates the request so imem sees no read while reset is held.
  assign issue = rst_n & ~redirect_i & (occupancy < 3'd2);

  assign imem_en_o   = issue;
  assign imem_addr_o = fetch_pc_q;

  // Returns are dropped when stale (kill_q) or when a redirect lands on the same cycle.
  assign enq            = inflight_q & ~kill_q & ~redirect_i;
  assign enq_entry.inst = imem_rdata_i;
  assign enq_entry.pc   = issue_pc_q;

  sync_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (2)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_i),
    .push     (enq),
    .push_dat (enq_entry),
    .pop      (deq),
    .head_dat (head),
    .count    (q_count)
  );

  // Fetch PC: redirect target wins, otherwise advance on each issued request (wraps silently).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
    end else if (redirect_i) begin
      fetch_pc_q <= redirect_pc_i;
    end else if (issue) begin
      fetch_pc_q <= fetch_pc_q + 1'b1;
    end
  end

  // Track the outstanding request and the PC it was issued for, to tag the return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      issue_pc_q <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) issue_pc_q <= fetch_pc_q;
    end
  end

  // A return must be killed only if a request was issued in the redirect cycle itself;
  // with single-cycle imem and no issue on redirect this stays low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill_q <= 1'b0;
    end else begin
      kill_q <= redirect_i & imem_en_o;
    end
  end

  assign inst_o    = if_valid_o ? head.inst : NOP_INST;
  assign pc_o      = if_valid_o ? head.pc : '0;
  assign pc_plus_o = if_valid_o ? head.pc + 1'b1 : '0;

`ifdef IF_PERF_CNT_EN
  // Accepted instructions and decode-ready-but-starved cycles, both free-running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt_o  <= 32'd0;
      perf_bubble_cnt_o <= 32'd0;
    end else begin
      if (deq)                      perf_fetch_cnt_o  <= perf_fetch_cnt_o + 32'd1;
      if (id_ready_i & ~if_valid_o) perf_bubble_cnt_o <= perf_bubble_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Holds the fetch PC and issues reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions in a 2-entry queue and presents them to decode with a valid/ready handshake.
- Handles redirects (taken branch/jump) by flushing queued and in-flight fetches and restarting at the target. PC is word-indexed: the next sequential PC is pc+1.

Parameters:
- PC_W, 32, width of the word-indexed PC and the imem address.
- INST_W, 32, instruction width.
- RESET_PC, 0, first word address fetched after reset.
- NOP_INST, 32'h00000013, value driven on inst_o when the queue is empty.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- imem_en_o  out  1  imem read request this cycle.
- imem_addr_o  out  PC_W  imem word address; equals fetch_pc.
- imem_rdata_i  in  INST_W  imem data; valid the cycle after a request.
- redirect_i  in  1  flush and restart fetch.
- redirect_pc_i  in  PC_W  restart word address; sampled when redirect_i=1.
- id_ready_i  in  1  decode accepts the head entry this cycle.
- if_valid_o  out  1  head entry valid.
- inst_o  out  INST_W  head instruction, or NOP_INST when empty.
- pc_o  out  PC_W  head PC, or 0 when empty.
- pc_plus_o  out  PC_W  pc_o+1 when valid, 0 when empty.

Behaviour:
- State:
  - fetch_pc: PC_W bits.
  - inflight_q: a request was issued last cycle.
  - kill_q: the in-flight return must be dropped.
  - queue: 2 entries of {inst, pc}, with head/tail pointers and count (0..2).
- Reset (rst_n=0, takes effect immediately):
  - fetch_pc=RESET_PC, inflight_q=0, kill_q=0, count=0.
  - if_valid_o=0, inst_o=NOP_INST, pc_o=0, pc_plus_o=0, imem_en_o=0.
- Dequeue: deq = if_valid_o & id_ready_i & ~redirect_i.
- Issue: issue = ~redirect_i & (count + inflight_q - deq < 2).
  - When issue=1: imem_en_o=1, imem_addr_o=fetch_pc, fetch_pc<=fetch_pc+1, inflight_q<=1.
  - When issue=0: inflight_q<=0.
  - fetch_pc wraps from 2^PC_W-1 to 0 with no flag.
- Return: in the cycle inflight_q=1, imem_rdata_i is written at tail with pc = fetch_pc-1 captured at issue.
  - Skipped if kill_q=1 or redirect_i=1.
  - Enqueue and dequeue in the same cycle are permitted; count is unchanged.
  - The issue rule guarantees the queue never overflows. An enqueue when full is a design error and must be flagged by a bench assertion.
- Outputs are driven from the head entry registers, so decode sees only registered values. Not valid until one cycle after the return.
- Redirect (redirect_i=1), in that cycle:
  - imem_en_o=0.
  - count<=0.
  - fetch_pc<=redirect_pc_i.
  - kill_q<=0, because no request is issued in the redirect cycle. A return arriving in the redirect cycle is dropped.
  - A redirect overrides a simultaneous dequeue and enqueue.
  - The target is requested at N+1, data returns at N+2, and if_valid_o=1 with pc_o=target at N+3.
  - Back-to-back redirects: the last one wins.
- Steady state with id_ready_i=1 held: one instruction per cycle.
  - First valid output two cycles after reset release: request in cycle 0, data in cycle 1, if_valid_o in cycle 2.
- Stall (id_ready_i=0):
  - Head outputs are held stable.
  - The queue fills to 2, then issue stops; fetch_pc holds at the first unissued address.
  - No instruction is lost or duplicated.
- kill_q is retained for future multi-cycle imem. With 1-cycle latency it is always 0 after a redirect cycle.

Optional Feature:
- IF_PERF_CNT_EN defined: adds outputs perf_fetch_cnt_o and perf_bubble_cnt_o, both 32 bits, both reset to 0, both wrapping.
  - perf_fetch_cnt_o increments on every deq.
  - perf_bubble_cnt_o increments each cycle where id_ready_i=1 and if_valid_o=0.
- IF_PERF_CNT_EN undefined: neither port nor any counter logic exists, and behaviour is otherwise identical.

Test Plan:
- Reset release with RESET_PC=0, id_ready_i=1, imem returning mem[a]=a+0x100 -> if_valid_o rises at cycle 2 with pc_o=0, inst_o=0x100, pc_plus_o=1; then pc_o=1,2,3 with one instruction per cycle.
- Stall: id_ready_i=0 for 5 cycles starting when pc_o=3 -> pc_o and inst_o held at 3/0x103, imem_en_o=0 after the queue fills to 2; on release the outputs run 3,4,5 with no gaps or duplicates.
- Redirect at cycle N with redirect_pc_i=0x40 while the queue holds 2 entries -> if_valid_o=0 at N+1 and N+2; if_valid_o=1 with pc_o=0x40 and inst_o=0x140 at N+3; the old entries are never accepted.
- Redirect with id_ready_i=1 and a return in the same cycle -> no dequeue counted, the returned instruction is dropped, and fetch restarts at the target.
- Wrap-around: RESET_PC=32'hFFFFFFFF -> pc_o sequence FFFFFFFF, 0, 1; pc_plus_o=0 when pc_o=FFFFFFFF.
- rst_n asserted mid-stream with 2 entries queued -> if_valid_o=0 and inst_o=NOP_INST immediately, without waiting for a clock edge. With IF_PERF_CNT_EN defined, both counters read 0 and then count 3 fetches and 2 bubbles over the next scripted sequence.
